fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage beside the VeriRISC controller.
//  - Holds the program counter (PC) and the instruction register (IR).
//  - Drives the opcode back to the controller.
//  - Consumes the controller's inc_pc, load_pc, load_ir and halt strobes.
//  - Drives the memory address: PC in fetch phases, IR operand otherwise.
// PARAMETERS
//  ADDR_W  5  memory address width; also the IR operand field width
//  DATA_W  8  instruction/data width; must equal ADDR_W+3 (elaboration $error otherwise)
// PORTS
//  clk      in   1       system clock, rising edge
//  rst_     in   1       asynchronous, active-low reset
//  data_in  in   DATA_W  memory read data (instruction during fetch)
//  fetch    in   1       1 = instruction-fetch phase (PC drives addr)
//  load_ir  in   1       capture data_in into IR
//  inc_pc   in   1       PC <= PC+1
//  load_pc  in   1       PC <= IR operand (JMP / SKZ skip target)
//  halt     in   1       controller halt strobe
//  opcode   out  3       opcode_t'(IR[DATA_W-1 -: 3]) to the controller
//  addr     out  ADDR_W  fetch ? PC : IR[ADDR_W-1:0]; combinational
//  pc       out  ADDR_W  current PC, for debug
//  ir       out  DATA_W  current IR
//  halted   out  1       sticky halt flag
//  icount   out  16      retired-instruction count (see CONFIGURATION)
// BEHAVIOUR
//  Reset values (async on rst_=0): pc=0, ir=0 (opcode HLT), halted=0, icount=0.
//    - addr follows fetch: 0 in either phase.
//  Reset mid-operation clears all state immediately, irrespective of clk.
//  PC update, per rising edge, in priority order:
//    - halted=1, or halt=1 this cycle: hold.
//    - else load_pc: pc <= ir[ADDR_W-1:0], using the IR value from before this edge.
//    - else inc_pc: pc <= pc+1, modulo 2**ADDR_W (31 -> 0 wraps, no flag).
//    - else hold.
//    - load_pc with inc_pc in the same cycle: load wins.
//  IR update:
//    - load_ir && !halted && !halt: ir <= data_in; else hold.
//    - load_ir with load_pc in the same cycle: PC takes the old operand; IR takes new data.
//  Halt:
//    - halted <= 1 on any edge with halt=1.
//    - Cleared only by rst_.
//    - Freezes PC, IR and icount from the same edge onward.
//  Latency:
//    - opcode/ir/pc valid the edge after their strobe.
//    - addr is zero-latency from fetch.
//  Strobes are level-sampled each edge; the controller guarantees one-cycle pulses.
//  No internal FSM decode: phase sequencing is owned entirely by the controller.
// CONFIGURATION
//  FETCH_ICOUNT_EN defined:
//    - icount += 1 on every accepted IR load (same gating as the IR update).
//    - Saturates at 16'hFFFF; never wraps.
//  FETCH_ICOUNT_EN undefined:
//    - icount tied to 16'h0000; no counter register is synthesised.
//    - Port list is unchanged.
// STRUCTURE
//  Package typedefs: opcode_t (existing), plus localparams OPC_W=3 and ICOUNT_W=16.
//  Sub-module pc_counter:
//    - ADDR_W-wide loadable counter with ports clk, rst_, load, enable, data, count.
//    - Load has priority over enable.
//    - fetch_unit gates load/enable with the halt logic.
//  IR register, address mux, halt flag and icount stay in fetch_unit.
// TESTING
//  T1: rst_=0 mid-run with pc=9 -> pc=0, ir=0, opcode=HLT, halted=0, icount=0 with no clock edge.
//  T2: inc_pc pulse 31 times from reset -> pc=31; one more pulse -> pc=0 (wrap).
//  T3: data_in=8'b111_01010, load_ir, then load_pc+inc_pc together
//      -> opcode=JMP, pc=10 (load priority); addr=10 with fetch=1.
//  T4: fetch=0 with ir=8'b101_00111 -> addr=7; fetch=1 with pc=3 -> addr=3, combinationally.
//  T5: halt=1 in the same cycle as load_ir/inc_pc -> pc, ir, icount unchanged; halted=1 sticky;
//      later strobes ignored until rst_.
//  T6 (FETCH_ICOUNT_EN): 5 accepted load_ir -> icount=5; force icount=16'hFFFF, load_ir -> stays FFFF.
//      Without the macro -> icount=0 throughout.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared opcode type and widths for the VeriRISC fetch stage
package fetch_unit_pkg;
  localparam int OPC_W = 3;
  localparam int ICOUNT_W = 16;
  typedef enum logic [OPC_W-1:0] {HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP} opcode_t;
endpackage

// File: rtl/fetch_unit_pc_counter.sv
// pc_counter: loadable wrapping program counter, load takes priority over enable
module pc_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] data,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) count <= '0;
    else if (load) count <= data;
    else if (enable) count <= count + 1'b1;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR fetch stage with sticky halt; optional retired-instruction
// counter enabled by defining FETCH_ICOUNT_EN
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                fetch,
  input  logic                load_ir,
  input  logic                inc_pc,
  input  logic                load_pc,
  input  logic                halt,
  output opcode_t             opcode,
  output logic [ADDR_W-1:0]   addr,
  output logic [ADDR_W-1:0]   pc,
  output logic [DATA_W-1:0]   ir,
  output logic                halted,
  output logic [ICOUNT_W-1:0] icount
);
  if (DATA_W != ADDR_W + OPC_W) begin : g_bad_width
    $error("fetch_unit: DATA_W must equal ADDR_W+3");
  end
  logic frozen, take_ir;
  // a halt strobe freezes state on the very edge it is seen
  assign frozen  = halted | halt;
  assign take_ir = load_ir & ~frozen;
  pc_counter #(.W(ADDR_W)) u_pc (
    .clk    (clk),
    .rst_   (rst_),
    .load   (load_pc & ~frozen),
    .enable (inc_pc & ~frozen),
    .data   (ir[ADDR_W-1:0]),
    .count  (pc)
  );
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) begin
      ir     <= '0;
      halted <= 1'b0;
    end else begin
      if (take_ir) ir <= data_in;
      if (halt) halted <= 1'b1;
    end
  assign opcode = opcode_t'(ir[DATA_W-1 -: OPC_W]);
  assign addr   = fetch ? pc : ir[ADDR_W-1:0];
`ifdef FETCH_ICOUNT_EN
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) icount <= '0;
    else if (take_ir && icount != '1) icount <= icount + 1'b1;
`else
  assign icount = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table vectors, directed corner sequences and random strobes vs a PC/IR model
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  logic clk = 0, rst_ = 0;
  logic [7:0] data_in = 0;
  logic fetch = 0, load_ir = 0, inc_pc = 0, load_pc = 0, halt = 0;
  opcode_t opcode;
  logic [4:0] addr, pc;
  logic [7:0] ir;
  logic halted;
  logic [15:0] icount;
  int n_pass = 0, n_total = 0;
  int m_pc, m_ir, m_cnt;
  bit m_halted;

  fetch_unit dut (
    .clk(clk), .rst_(rst_), .data_in(data_in), .fetch(fetch), .load_ir(load_ir),
    .inc_pc(inc_pc), .load_pc(load_pc), .halt(halt), .opcode(opcode), .addr(addr),
    .pc(pc), .ir(ir), .halted(halted), .icount(icount)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit f, li, ip, lp, h;
    logic [7:0] d;
    int pc, ir, addr;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int exp_icount();
`ifdef FETCH_ICOUNT_EN
    return m_cnt > 65535 ? 65535 : m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, ".pc"}, 32'(pc), m_pc);
    chk({tag, ".ir"}, 32'(ir), m_ir);
    chk({tag, ".opcode"}, 32'(opcode), m_ir / 32);
    chk({tag, ".addr"}, 32'(addr), fetch ? m_pc : m_ir % 32);
    chk({tag, ".halted"}, 32'(halted), 32'(m_halted));
    chk({tag, ".icount"}, 32'(icount), exp_icount());
  endtask

  // Inputs are applied after the previous check (posedge+1), model advances on the edge
  task automatic step(input string tag, input bit f, li, ip, lp, h, input logic [7:0] d);
    fetch = f; load_ir = li; inc_pc = ip; load_pc = lp; halt = h; data_in = d;
    @(posedge clk);
    if (!(m_halted || h)) begin
      if (lp) m_pc = m_ir % 32;
      else if (ip) m_pc = (m_pc + 1) % 32;
      if (li) begin m_ir = d; m_cnt++; end
    end
    if (h) m_halted = 1;
    #1;
    chk_all(tag);
  endtask

  // Asserted and released between edges; state must clear with no clock edge
  task automatic do_reset(input string tag);
    #1 rst_ = 0;
    m_pc = 0; m_ir = 0; m_cnt = 0; m_halted = 0;
    fetch = 1; load_ir = 0; inc_pc = 0; load_pc = 0; halt = 0;
    #1 chk_all(tag);
    rst_ = 1;
  endtask

  initial begin
    tbl[0] = '{1, 1, 0, 0, 0, 8'hEA, 0, 'hEA, 0};
    tbl[1] = '{1, 0, 1, 1, 0, 8'h00, 10, 'hEA, 10};
    tbl[2] = '{0, 0, 1, 0, 0, 8'h00, 11, 'hEA, 10};
    tbl[3] = '{0, 1, 0, 1, 0, 8'hA7, 10, 'hA7, 7};
    tbl[4] = '{1, 0, 0, 1, 0, 8'h00, 7, 'hA7, 7};
    tbl[5] = '{1, 0, 1, 0, 0, 8'h00, 8, 'hA7, 8};
    tbl[6] = '{0, 0, 0, 0, 0, 8'h00, 8, 'hA7, 7};
    m_pc = 0; m_ir = 0; m_cnt = 0; m_halted = 0;
    #2 chk_all("reset");
    @(posedge clk); #1;
    do_reset("reset0");

    for (int i = 0; i < 7; i++) begin
      step($sformatf("tbl%0d", i), tbl[i].f, tbl[i].li, tbl[i].ip, tbl[i].lp, tbl[i].h, tbl[i].d);
      chk($sformatf("tbl%0d.pc_const", i), 32'(pc), tbl[i].pc);
      chk($sformatf("tbl%0d.ir_const", i), 32'(ir), tbl[i].ir);
      chk($sformatf("tbl%0d.addr_const", i), 32'(addr), tbl[i].addr);
      if (i == 1) chk("tbl1.opcode_jmp", 32'(opcode), 32'(JMP));
    end

    fetch = 0; #1 chk("comb_addr_ir", 32'(addr), 7);
    fetch = 1; #1 chk("comb_addr_pc", 32'(addr), 8);
    @(posedge clk); #1;

    do_reset("reset_t1a");
    for (int i = 0; i < 9; i++) step("t1_inc", 1, 0, 1, 0, 0, 8'h00);
    chk("t1_pc9", 32'(pc), 9);
    step("t1_load", 1, 1, 0, 0, 0, 8'h55);
    do_reset("t1_async");
    chk("t1_pc_zero", 32'(pc), 0);
    chk("t1_opcode_hlt", 32'(opcode), 32'(HLT));

    for (int i = 0; i < 31; i++) step("t2_inc", 1, 0, 1, 0, 0, 8'h00);
    chk("t2_pc31", 32'(pc), 31);
    step("t2_wrap", 1, 0, 1, 0, 0, 8'h00);
    chk("t2_pc0", 32'(pc), 0);

    do_reset("reset_t5");
    step("t5_pre", 1, 1, 1, 0, 0, 8'h45);
    step("t5_halt", 1, 1, 1, 0, 1, 8'hEA);
    chk("t5_ir_held", 32'(ir), 'h45);
    chk("t5_pc_held", 32'(pc), 1);
    chk("t5_halted", 32'(halted), 1);
    step("t5_ign_ld", 1, 1, 0, 1, 0, 8'h3C);
    step("t5_ign_inc", 0, 0, 1, 0, 0, 8'h00);
    chk("t5_sticky", 32'(halted), 1);
    chk("t5_ir_still", 32'(ir), 'h45);

    do_reset("reset_t6");
    for (int i = 0; i < 5; i++) step("t6_ld", 1, 1, 0, 0, 0, 8'(i + 1));
    chk("t6_icount5", 32'(icount), exp_icount());
`ifdef FETCH_ICOUNT_EN
    chk("t6_icount5_const", 32'(icount), 5);
    load_ir = 1; inc_pc = 0; load_pc = 0;
    repeat (65530) @(posedge clk);
    m_ir = data_in; m_cnt += 65530;
    #1 chk("t6_icount_ffff", 32'(icount), 16'hFFFF);
    step("t6_sat", 1, 1, 0, 0, 0, 8'h11);
    chk("t6_sat_const", 32'(icount), 16'hFFFF);
`else
    chk("t6_icount_zero", 32'(icount), 0);
`endif

    do_reset("reset_rand");
    for (int i = 0; i < 400; i++) begin
      if (m_halted && $urandom_range(0, 3) == 0) do_reset("rand_reset");
      step("rand", 1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 39) == 0), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
